// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared types and constants for the 68000-style interrupt-acknowledge sequencer.
package interrupt_ack_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACK       = 2'd1,
        WAIT_HIGH = 2'd2
    } state_t;

    localparam logic [2:0] FC_CPU_SPACE    = 3'b111;
    localparam logic [7:0] SPURIOUS_VECTOR = 8'h18;

    function automatic logic [7:0] vector_byte(input logic [4:0] base_hi, input logic [2:0] lvl);
        return {base_hi, lvl};
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module saturating_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Answers IACK bus cycles with a vector byte, an autovector request or the spurious vector.
module interrupt_ack_sequencer
    import interrupt_ack_sequencer_pkg::*;
#(
    parameter logic [7:0]  AUTOVEC_MASK = 8'h00,
    parameter logic [7:0]  EDGE_MASK    = 8'hF0,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       host_as_n,
    input  logic [2:0] host_fc,
    input  logic [2:0] host_address,
    input  logic [2:0] intc_priority,
    input  logic       intc_priority_gs,
    input  logic [7:0] intc_vector,
    output logic [7:0] host_qout,
    output logic       host_qout_oe,
    output logic       host_dtack_n,
    output logic       host_vpa_n,
    output logic       pend_clr_we,
    output logic [7:0] pend_clr_mask,
    output logic [7:0] spurious_count,
    output logic       timeout_err
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [TW-1:0] t_count;
    logic          iack;
    logic          valid;
    logic          spurious_inc;
    logic          unused_vector_bits;

    always_comb begin
        iack               = (state == IDLE) && !host_as_n && (host_fc == FC_CPU_SPACE);
        valid              = intc_priority_gs && (intc_priority == host_address) && (host_address != 3'd0);
        spurious_inc       = iack && !valid;
        unused_vector_bits = ^intc_vector[2:0];
    end

    saturating_counter #(.WIDTH(8)) u_spurious (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (spurious_inc),
        .count   (spurious_count)
    );

    // The response registers themselves hold the captured level; no separate
    // copy is needed, and later priority changes cannot disturb them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            t_count       <= '0;
            host_qout     <= '0;
            host_qout_oe  <= 1'b0;
            host_dtack_n  <= 1'b1;
            host_vpa_n    <= 1'b1;
            pend_clr_we   <= 1'b0;
            pend_clr_mask <= '0;
            timeout_err   <= 1'b0;
        end else begin
            pend_clr_we   <= 1'b0;
            pend_clr_mask <= '0;
            timeout_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (iack) begin
                        state   <= ACK;
                        t_count <= '0;
                        if (!valid) begin
                            host_qout    <= SPURIOUS_VECTOR;
                            host_qout_oe <= 1'b1;
                            host_dtack_n <= 1'b0;
                        end else if (AUTOVEC_MASK[host_address]) begin
                            host_vpa_n <= 1'b0;
                        end else begin
                            host_qout    <= vector_byte(intc_vector[7:3], host_address);
                            host_qout_oe <= 1'b1;
                            host_dtack_n <= 1'b0;
                        end
                        if (valid && EDGE_MASK[host_address]) begin
                            pend_clr_we   <= 1'b1;
                            pend_clr_mask <= 8'b1 << host_address;
                        end
                    end
                end
                ACK: begin
                    // Release wins over timeout when both fall on the same edge.
                    if (host_as_n) begin
                        state        <= IDLE;
                        host_qout    <= '0;
                        host_qout_oe <= 1'b0;
                        host_dtack_n <= 1'b1;
                        host_vpa_n   <= 1'b1;
                    end else if (t_count == T_LAST) begin
                        state        <= WAIT_HIGH;
                        timeout_err  <= 1'b1;
                        host_qout    <= '0;
                        host_qout_oe <= 1'b0;
                        host_dtack_n <= 1'b1;
                        host_vpa_n   <= 1'b1;
                    end else begin
                        t_count <= t_count + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (host_as_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed self-checking bench for interrupt_ack_sequencer (autovector on level 3, TIMEOUT=8).
module tb_interrupt_ack_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       host_as_n;
    logic [2:0] host_fc;
    logic [2:0] host_address;
    logic [2:0] intc_priority;
    logic       intc_priority_gs;
    logic [7:0] intc_vector;
    logic [7:0] host_qout;
    logic       host_qout_oe;
    logic       host_dtack_n;
    logic       host_vpa_n;
    logic       pend_clr_we;
    logic [7:0] pend_clr_mask;
    logic [7:0] spurious_count;
    logic       timeout_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clock = ~clock;

    interrupt_ack_sequencer #(
        .AUTOVEC_MASK (8'h08),
        .EDGE_MASK    (8'hF0),
        .TIMEOUT      (8)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .host_as_n        (host_as_n),
        .host_fc          (host_fc),
        .host_address     (host_address),
        .intc_priority    (intc_priority),
        .intc_priority_gs (intc_priority_gs),
        .intc_vector      (intc_vector),
        .host_qout        (host_qout),
        .host_qout_oe     (host_qout_oe),
        .host_dtack_n     (host_dtack_n),
        .host_vpa_n       (host_vpa_n),
        .pend_clr_we      (pend_clr_we),
        .pend_clr_mask    (pend_clr_mask),
        .spurious_count   (spurious_count),
        .timeout_err      (timeout_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " qout"}, 32'(host_qout), 32'h00);
        check({tag, " qout_oe"}, 32'(host_qout_oe), 32'h0);
        check({tag, " dtack_n"}, 32'(host_dtack_n), 32'h1);
        check({tag, " vpa_n"}, 32'(host_vpa_n), 32'h1);
        check({tag, " pend_we"}, 32'(pend_clr_we), 32'h0);
        check({tag, " pend_mask"}, 32'(pend_clr_mask), 32'h00);
        check({tag, " spur_cnt"}, 32'(spurious_count), 32'h00);
        check({tag, " tmo_err"}, 32'(timeout_err), 32'h0);
    endtask

    initial begin
        int unsigned pulses;
        reset_n          = 1'b0;
        host_as_n        = 1'b1;
        host_fc          = 3'b000;
        host_address     = 3'd0;
        intc_priority    = 3'd0;
        intc_priority_gs = 1'b0;
        intc_vector      = 8'h00;
        tick();
        tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Level 6, edge-latched, vectored.
        intc_priority = 3'd6; intc_priority_gs = 1'b1; intc_vector = 8'h40;
        host_address = 3'd6; host_fc = 3'b111; host_as_n = 1'b0;
        tick();
        check("l6 qout", 32'(host_qout), 32'h46);
        check("l6 qout_oe", 32'(host_qout_oe), 32'h1);
        check("l6 dtack_n", 32'(host_dtack_n), 32'h0);
        check("l6 vpa_n", 32'(host_vpa_n), 32'h1);
        check("l6 pend_we", 32'(pend_clr_we), 32'h1);
        check("l6 pend_mask", 32'(pend_clr_mask), 32'h40);
        tick();
        check("l6 pend_we 2nd", 32'(pend_clr_we), 32'h0);
        check("l6 dtack held", 32'(host_dtack_n), 32'h0);
        host_as_n = 1'b1;
        tick();
        check("l6 rel dtack_n", 32'(host_dtack_n), 32'h1);
        check("l6 rel qout_oe", 32'(host_qout_oe), 32'h0);

        // Level 3 autovector, level-sensitive.
        intc_priority = 3'd3; host_address = 3'd3; host_as_n = 1'b0;
        tick();
        check("l3 vpa_n", 32'(host_vpa_n), 32'h0);
        check("l3 qout_oe", 32'(host_qout_oe), 32'h0);
        check("l3 dtack_n", 32'(host_dtack_n), 32'h1);
        check("l3 pend_we", 32'(pend_clr_we), 32'h0);
        host_as_n = 1'b1;
        tick();
        check("l3 rel vpa_n", 32'(host_vpa_n), 32'h1);

        // Ordinary bus cycle is ignored.
        host_fc = 3'b101; host_as_n = 1'b0;
        tick();
        check("nofc dtack_n", 32'(host_dtack_n), 32'h1);
        check("nofc vpa_n", 32'(host_vpa_n), 32'h1);
        host_as_n = 1'b1; host_fc = 3'b111;
        tick();

        // Spurious: group-select low.
        intc_priority_gs = 1'b0; intc_priority = 3'd5; host_address = 3'd5; host_as_n = 1'b0;
        tick();
        check("spur qout", 32'(host_qout), 32'h18);
        check("spur qout_oe", 32'(host_qout_oe), 32'h1);
        check("spur dtack_n", 32'(host_dtack_n), 32'h0);
        check("spur count", 32'(spurious_count), 32'h01);
        check("spur pend_we", 32'(pend_clr_we), 32'h0);
        host_as_n = 1'b1;
        tick();

        // Priority change mid-ACK must not disturb the response.
        intc_priority_gs = 1'b1; intc_priority = 3'd7; host_address = 3'd7; host_as_n = 1'b0;
        tick();
        check("l7 pend_mask", 32'(pend_clr_mask), 32'h80);
        tick();
        intc_priority = 3'd4;
        tick();
        tick();
        check("prio chg qout", 32'(host_qout), 32'h47);
        check("prio chg dtack_n", 32'(host_dtack_n), 32'h0);
        host_as_n = 1'b1;
        tick();

        // Timeout: strobe held low for 20 cycles.
        intc_priority = 3'd6; host_address = 3'd6; host_as_n = 1'b0;
        tick();
        pulses = 0;
        for (int unsigned k = 1; k <= 20; k++) begin
            tick();
            if (timeout_err) pulses++;
            if (k < 8) begin
                check($sformatf("tmo dtack k=%0d", k), 32'(host_dtack_n), 32'h0);
            end else begin
                check($sformatf("tmo dtack k=%0d", k), 32'(host_dtack_n), 32'h1);
            end
            if (k == 8) check("tmo err pulse", 32'(timeout_err), 32'h1);
        end
        check("tmo pulse count", pulses, 32'd1);
        host_as_n = 1'b1;
        tick();
        host_as_n = 1'b0;
        tick();
        check("tmo rearm dtack_n", 32'(host_dtack_n), 32'h0);
        host_as_n = 1'b1;
        tick();

        // Release at count TIMEOUT-1 beats the timeout.
        host_as_n = 1'b0;
        tick();
        repeat (7) tick();
        check("late rel dtack held", 32'(host_dtack_n), 32'h0);
        host_as_n = 1'b1;
        tick();
        check("late rel tmo_err", 32'(timeout_err), 32'h0);
        check("late rel dtack_n", 32'(host_dtack_n), 32'h1);
        tick();
        check("late rel tmo_err 2", 32'(timeout_err), 32'h0);

        // Asynchronous reset in the middle of an ACK.
        host_as_n = 1'b0;
        tick();
        check("pre-rst dtack_n", 32'(host_dtack_n), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async rst");
        #3;
        reset_n = 1'b1;
        tick();
        check("post-rst dtack_n", 32'(host_dtack_n), 32'h0);
        check("post-rst qout", 32'(host_qout), 32'h46);
        check("post-rst pend_we", 32'(pend_clr_we), 32'h1);
        host_as_n = 1'b1;
        tick();

        // Spurious counter saturation.
        intc_priority_gs = 1'b0;
        for (int unsigned i = 0; i < 300; i++) begin
            host_as_n = 1'b0;
            tick();
            host_as_n = 1'b1;
            tick();
            if (i == 253) check("spur cnt 254", 32'(spurious_count), 32'hFE);
            if (i == 254) check("spur cnt 255", 32'(spurious_count), 32'hFF);
        end
        check("spur cnt sat", 32'(spurious_count), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
# interrupt_ack_sequencer

Services 68000-style interrupt-acknowledge (IACK) bus cycles on behalf of the interrupt controller. It detects an IACK cycle and answers it with either a vectored response (vector byte plus DTACK) or an autovector response (VPA). For edge-latched levels it issues a one-cycle clear strobe into the controller's pending-clear path, so the acknowledged source is retired. It also counts spurious acknowledges and bounds every handshake with a timeout.

## Interface
- `AUTOVEC_MASK`, default 8'h00: bit n=1 means level n is answered by autovector (VPA), not by a vector byte.
- `EDGE_MASK`, default 8'hF0: bit n=1 means level n is edge-latched and gets a pending-clear strobe on acknowledge.
- `TIMEOUT`, default 64: the maximum number of cycles ACK may be held before it is forcibly released. Must be ≥2.
- `clock`  in  1  system clock; all inputs are synchronous to it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `host_as_n`  in  1  CPU address strobe.
- `host_fc`  in  3  CPU function code; 3'b111 identifies CPU space.
- `host_address`  in  3  address bits A3..A1, which carry the level being acknowledged.
- `intc_priority`  in  3  current encoded priority from the controller.
- `intc_priority_gs`  in  1  group-select; 1 means `intc_priority` is valid.
- `intc_vector`  in  8  vector base register from the controller.
- `host_qout`  out  8  vector byte.
- `host_qout_oe`  out  1  drive enable for `host_qout`.
- `host_dtack_n`  out  1  data acknowledge, active low.
- `host_vpa_n`  out  1  valid peripheral address (autovector request), active low.
- `pend_clr_we`  out  1  one-cycle pulse that writes the pending-clear register.
- `pend_clr_mask`  out  8  one-hot bit to clear; valid only while `pend_clr_we`=1.
- `spurious_count`  out  8  saturating count of spurious acknowledges.
- `timeout_err`  out  1  one-cycle pulse when an ACK is released by timeout.

## Operation
- The detect condition `iack` is: `host_as_n`=0, `host_fc`=3'b111, and the block is in IDLE.
- IDLE
  - On `iack`, capture `lvl` = `host_address`.
  - Compute `valid` = `intc_priority_gs` & (`intc_priority` == `lvl`) & (`lvl` != 0).
  - Go to ACK.
- ACK, response selection (evaluated on the captured values):
  - `!valid`: spurious. Set `host_qout`=8'h18 with `host_qout_oe`=1 and `host_dtack_n`=0. Increment `spurious_count`; it saturates at 8'hFF. No clear strobe.
  - `valid` & `AUTOVEC_MASK[lvl]`: assert `host_vpa_n`=0. `host_qout_oe` and `host_dtack_n` stay inactive.
  - `valid` & !`AUTOVEC_MASK[lvl]`: set `host_qout` = {`intc_vector[7:3]`, `lvl`}, with `host_qout_oe`=1 and `host_dtack_n`=0.
  - `valid` & `EDGE_MASK[lvl]`: `pend_clr_we`=1 for exactly the first ACK cycle, with `pend_clr_mask` = 1<<`lvl`.
- ACK, exit:
  - When `host_as_n`=1, go to IDLE. All responses are released on that same edge.
  - When the timeout counter reaches `TIMEOUT`-1 while `host_as_n` is still 0: pulse `timeout_err`, release all responses, go to WAIT_HIGH.
- WAIT_HIGH: outputs are inactive. Go to IDLE once `host_as_n`=1. This prevents the same strobe from re-triggering.
- Non-IACK bus cycles (`host_fc` != 3'b111) are ignored in every state.

## Timing
- All outputs are registered.
- Reset values:
  - `host_qout`=8'h00, `host_qout_oe`=0.
  - `host_dtack_n`=1, `host_vpa_n`=1.
  - `pend_clr_we`=0, `pend_clr_mask`=8'h00.
  - `spurious_count`=8'h00, `timeout_err`=0.
  - State = IDLE, timeout counter = 0.
- Latency: `iack` sampled at edge N → responses valid from N+1. `pend_clr_we` is high only during cycle N+1 → N+2.
- Release: `host_as_n` sampled high at edge M → `host_dtack_n`, `host_vpa_n` and `host_qout_oe` are inactive after M.
- Timeout counter:
  - Clears on entry to ACK and increments once per ACK cycle.
  - An ACK lasting exactly `TIMEOUT` cycles with the strobe still low times out.
  - An ACK released at count `TIMEOUT`-1 does not time out, because release has priority over timeout on the same edge.
- A priority change after capture does not alter an in-progress response.
- Reset asserted mid-ACK returns all outputs to their reset values immediately (asynchronously).

## Structure
- Shared package holds:
  - FSM state encoding: IDLE, ACK, WAIT_HIGH.
  - `FC_CPU_SPACE` = 3'b111.
  - `SPURIOUS_VECTOR` = 8'h18.
- One sub-module, `saturating_counter`, with parameterised width, used for `spurious_count`.
- The timeout counter is inline. Its width is $clog2(`TIMEOUT`).

## Test plan
- Level 6 edge, vectored: priority=6, gs=1, vector=8'h40, IACK with A=6 → `host_qout`=8'h46 and `host_dtack_n`=0 at N+1. One `pend_clr_we` pulse with mask 8'h40. Responses released the cycle after AS goes high.
- Level 3 autovector: `AUTOVEC_MASK`=8'h08, priority=3, IACK with A=3 → `host_vpa_n`=0, `host_qout_oe`=0, no `pend_clr_we`.
- Spurious:
  - gs=0, IACK with A=5 → `host_qout`=8'h18, DTACK asserted, `spurious_count`=1.
  - 300 spurious cycles → `spurious_count` holds at 8'hFF.
- Priority change during ACK: start IACK at level 7, then change priority to 4 in cycle N+2 → `host_qout` stays {base,3'd7}.
- Timeout:
  - `TIMEOUT`=8, AS held low for 20 cycles → `timeout_err` pulses once after the 8th ACK cycle, DTACK released, no new ACK until AS goes high then low again.
  - Release at the 7th cycle → no `timeout_err`.
- Reset mid-ACK: assert `reset_n`=0 while `host_dtack_n`=0 → all outputs at reset values without waiting for a clock edge. After reset release with AS still low and FC=111, a fresh ACK starts.
